// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational ROM read port between fetch and data requesters
module rom_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ROM_LENGTH = 256,
  parameter int IF_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  input  logic                  if_flush,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  dm_req_valid,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr,
  output logic                  dm_req_ready,
  output logic                  dm_rsp_valid,
  output logic [DATA_WIDTH-1:0] dm_rsp_data,
  output logic                  dm_rsp_err,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;
  localparam logic [3:0] BURST = 4'(IF_BURST);
  localparam logic [ADDR_WIDTH:0] LEN = (ADDR_WIDTH+1)'(ROM_LENGTH);
  owner_t owner;
  logic [3:0] starve_cnt;
  logic err1;
  logic if_hit;
  always_comb begin
    dm_req_ready = !rst && dm_req_valid && (!if_req_valid || starve_cnt >= BURST);
    if_req_ready = !rst && if_req_valid && !dm_req_ready;
    if_hit = owner == OWN_IF && !if_flush;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      owner <= OWN_NONE;
      err1 <= 1'b0;
      rom_addr <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data <= '0;
      dm_rsp_valid <= 1'b0;
      dm_rsp_data <= '0;
      dm_rsp_err <= 1'b0;
    end else begin
      starve_cnt <= (dm_req_ready || !dm_req_valid) ? '0 :
                    (if_req_ready && starve_cnt != 4'hf) ? starve_cnt + 4'd1 : starve_cnt;
      owner <= if_req_ready ? OWN_IF : dm_req_ready ? OWN_DM : OWN_NONE;
      rom_addr <= if_req_ready ? if_req_addr : dm_req_ready ? dm_req_addr : rom_addr;
      err1 <= {1'b0, dm_req_addr} >= LEN;
      if_rsp_valid <= if_hit;
      if_rsp_data <= if_hit ? rom_data : if_rsp_data;
      dm_rsp_valid <= owner == OWN_DM;
      dm_rsp_data <= owner == OWN_DM ? (err1 ? '0 : rom_data) : dm_rsp_data;
      dm_rsp_err <= owner == OWN_DM && err1;
    end
  end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: table, directed and random checks against a queue-based response model
module tb_rom_port_arbiter;
  localparam int IF_BURST = 4;
  logic clk = 1'b0;
  logic rst, if_req_valid, if_flush, dm_req_valid;
  logic [15:0] if_req_addr, dm_req_addr, rom_addr, rom_data, if_rsp_data, dm_rsp_data;
  logic if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid, dm_rsp_err;
  int n_vec = 0, n_bad = 0, cyc = 0;
  typedef struct {int due; bit dm; logic [15:0] data; bit err;} rsp_t;
  rsp_t q[$];
  logic [15:0] m_if = 16'h0, m_dm = 16'h0, m_addr = 16'h0;
  int m_cnt = 0;
  typedef struct {
    logic iv; logic [15:0] ia; logic dv; logic [15:0] da;
    logic eir, edr, eiv; logic [15:0] eid; logic edv; logic [15:0] edd; logic ede;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    int ai, b0, b1;
    ai = int'(a);
    b0 = ai < 256 ? (ai + 1) % 256 : 0;
    b1 = ai + 1 < 256 ? (ai + 2) % 256 : 0;
    return 16'(b1 * 256 + b0);
  endfunction

  assign rom_data = rom_word(rom_addr);

  rom_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .ROM_LENGTH(256), .IF_BURST(IF_BURST)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .dm_rsp_err(dm_rsp_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [15:0] ia, input logic fl,
                      input logic dv, input logic [15:0] da);
    logic exp_iv, exp_dv, exp_err, gi, gd;
    rsp_t e;
    @(negedge clk);
    exp_iv = 1'b0;
    exp_dv = 1'b0;
    exp_err = 1'b0;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.dm) begin
        exp_dv = 1'b1;
        m_dm = e.data;
        exp_err = e.err;
      end else begin
        exp_iv = 1'b1;
        m_if = e.data;
      end
    end
    chk("if_rsp_valid", 32'(if_rsp_valid), 32'(exp_iv));
    chk("if_rsp_data", 32'(if_rsp_data), 32'(m_if));
    chk("dm_rsp_valid", 32'(dm_rsp_valid), 32'(exp_dv));
    chk("dm_rsp_data", 32'(dm_rsp_data), 32'(m_dm));
    if (exp_dv) chk("dm_rsp_err", 32'(dm_rsp_err), 32'(exp_err));
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    rst = r;
    if_req_valid = iv;
    if_req_addr = ia;
    if_flush = fl;
    dm_req_valid = dv;
    dm_req_addr = da;
    #1;
    gd = !r && dv && (!iv || m_cnt >= IF_BURST);
    gi = !r && iv && !gd;
    chk("if_req_ready", 32'(if_req_ready), 32'(gi));
    chk("dm_req_ready", 32'(dm_req_ready), 32'(gd));
    if (r) begin
      q.delete();
      m_if = 16'h0;
      m_dm = 16'h0;
      m_addr = 16'h0;
      m_cnt = 0;
    end else begin
      if (fl)
        for (int i = q.size() - 1; i >= 0; i--)
          if (!q[i].dm && q[i].due == cyc + 1) q.delete(i);
      if (gi) begin
        q.push_back('{due: cyc + 2, dm: 1'b0, data: rom_word(ia), err: 1'b0});
        m_addr = ia;
      end
      if (gd) begin
        q.push_back('{due: cyc + 2, dm: 1'b1, data: (da < 16'd256) ? rom_word(da) : 16'h0,
                      err: (da >= 16'd256)});
        m_addr = da;
      end
      m_cnt = (gd || !dv) ? 0 : gi ? (m_cnt < 15 ? m_cnt + 1 : 15) : m_cnt;
    end
    cyc++;
  endtask

  function automatic logic [15:0] rand_addr();
    int s;
    s = int'($urandom_range(0, 9));
    return s == 0 ? 16'($urandom) : s == 1 ? 16'($urandom_range(254, 257)) : 16'($urandom_range(0, 255));
  endfunction

  initial begin
    tbl[0] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[2] = '{1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0201, 1'b0, 16'h0000, 1'b0};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 16'h00fe, 1'b0, 1'b1, 1'b1, 16'h0302, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 16'h00ff, 1'b0, 1'b1, 1'b1, 16'h0403, 1'b0, 16'h0000, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b0, 16'h0403, 1'b1, 16'h00ff, 1'b0};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0403, 1'b1, 16'h0000, 1'b0};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0403, 1'b1, 16'h0000, 1'b1};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0403, 1'b0, 16'h0000, 1'b0};
    rst = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr = 16'h0005;
    if_flush = 1'b0;
    dm_req_valid = 1'b1;
    dm_req_addr = 16'h0006;
    @(posedge clk);
    #1;
    chk("rst_if_ready", 32'(if_req_ready), 32'd0);
    chk("rst_dm_ready", 32'(dm_req_ready), 32'd0);
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, tbl[i].iv, tbl[i].ia, 1'b0, tbl[i].dv, tbl[i].da);
      chk("tbl_if_ready", 32'(if_req_ready), 32'(tbl[i].eir));
      chk("tbl_dm_ready", 32'(dm_req_ready), 32'(tbl[i].edr));
      chk("tbl_if_valid", 32'(if_rsp_valid), 32'(tbl[i].eiv));
      chk("tbl_if_data", 32'(if_rsp_data), 32'(tbl[i].eid));
      chk("tbl_dm_valid", 32'(dm_rsp_valid), 32'(tbl[i].edv));
      chk("tbl_dm_data", 32'(dm_rsp_data), 32'(tbl[i].edd));
      if (tbl[i].edv) chk("tbl_dm_err", 32'(dm_rsp_err), 32'(tbl[i].ede));
    end
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    for (int j = 0; j < 15; j++) begin
      step(1'b0, 1'b1, 16'(16'h30 + j), 1'b0, 1'b1, 16'(16'h80 + j));
      chk("burst_dm_grant", 32'(dm_req_ready), 32'(j % 5 == 4));
    end
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("flush_suppressed", 32'(if_rsp_valid), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("flush_target_valid", 32'(if_rsp_valid), 32'd1);
    chk("flush_target_data", 32'(if_rsp_data), 32'h4241);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0020);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("rst_drop_valid", 32'(dm_rsp_valid), 32'd0);
    chk("rst_if_data", 32'(if_rsp_data), 32'd0);
    chk("rst_dm_data", 32'(dm_rsp_data), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_dm_err", 32'(dm_rsp_err), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0021);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("post_rst_valid", 32'(dm_rsp_valid), 32'd1);
    chk("post_rst_data", 32'(dm_rsp_data), 32'h2322);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'(16'h50 + j));
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      chk("dm_run_valid", 32'(dm_rsp_valid), 32'(j < 2));
      chk("idle_rom_addr", 32'(rom_addr), 32'h0052);
    end
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, rand_addr(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, rand_addr());
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
